// File: rtl/mdu_issue_ctrl.sv
// Issue and sequencing controller for the shared iterative multiplier and divider.
// Prepares operands, resolves divide-by-zero/overflow locally and formats the result.
module mdu_issue_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_flag,
    input  logic             ready_flag,
    input  logic             req_valid,
    input  logic             req_is_div,
    input  logic [1:0]       req_mul_signed,
    input  logic             req_mul_high,
    input  logic             req_div_signed,
    input  logic             req_div_rem,
    input  logic             req_word,
    input  logic [XLEN-1:0]  req_op1,
    input  logic [XLEN-1:0]  req_op2,
    output logic             mul_valid,
    output logic [1:0]       mul_signed,
    output logic [XLEN-1:0]  mul_a,
    output logic [XLEN-1:0]  mul_b,
    input  logic             mul_o_valid,
    input  logic [XLEN-1:0]  mul_result_hi,
    input  logic [XLEN-1:0]  mul_result_lo,
    output logic             div_valid,
    output logic             div_signed,
    output logic [XLEN-1:0]  dividend,
    output logic [XLEN-1:0]  divisor,
    input  logic             div_o_valid,
    input  logic [XLEN-1:0]  quotient,
    input  logic [XLEN-1:0]  remainder,
    output logic             unit_o_ready,
    output logic             unit_flush,
    output logic             stall_req,
    output logic             o_valid,
    output logic [XLEN-1:0]  res,
    output logic [CNT_W-1:0] busy_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        r       = sgn ? {XLEN{v[31]}} : {XLEN{1'b0}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] fmt_result(
        input logic            is_div,
        input logic            high,
        input logic            rem,
        input logic            word,
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo,
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r
    );
        logic [XLEN-1:0] sel;
        if (is_div) begin
            sel = rem ? r : q;
        end else if (word) begin
            sel = lo;
        end else begin
            sel = high ? hi : lo;
        end
        return word ? ext32(sel[31:0], 1'b1) : sel;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [XLEN-1:0]   res_r;
    logic [XLEN-1:0]   res_nxt_s;
    logic              o_valid_r;
    logic [CNT_W-1:0]  busy_cycles_r;
    logic              is_div_r;
    logic              high_r;
    logic              rem_r;
    logic              word_r;

    logic [XLEN-1:0]   dividend_s;
    logic [XLEN-1:0]   divisor_s;
    logic              accept_s;
    logic              div0_s;
    logic              ovf_s;
    logic              special_s;
    logic              launch_s;
    logic              unit_done_s;
    logic [XLEN-1:0]   spec_q_s;
    logic [XLEN-1:0]   spec_r_s;

    // Operand preparation and divide special-case detection
    always_comb begin
        dividend_s = req_op1;
        divisor_s  = req_op2;
        if (req_is_div && req_word) begin
            dividend_s = ext32(req_op1[31:0], req_div_signed);
            divisor_s  = ext32(req_op2[31:0], req_div_signed);
        end else begin
            dividend_s = req_op1;
            divisor_s  = req_op2;
        end
        div0_s = (divisor_s == ZERO);
        if (req_word) begin
            ovf_s = req_div_signed && (dividend_s[31:0] == 32'h8000_0000)
                    && (divisor_s[31:0] == 32'hFFFF_FFFF);
        end else begin
            ovf_s = req_div_signed && (dividend_s == MOST_NEG) && (divisor_s == ALL_ONES);
        end
        special_s = req_is_div && (div0_s || ovf_s);
        spec_q_s  = div0_s ? ALL_ONES : dividend_s;
        spec_r_s  = div0_s ? dividend_s : ZERO;
    end

    assign accept_s     = (state_r == IDLE) && req_valid && !flush_flag;
    assign launch_s     = accept_s && !special_s;
    assign unit_done_s  = is_div_r ? div_o_valid : mul_o_valid;

    assign mul_valid    = launch_s && !req_is_div;
    assign div_valid    = launch_s && req_is_div;
    assign mul_signed   = req_mul_signed;
    assign div_signed   = req_div_signed;
    assign mul_a        = req_op1;
    assign mul_b        = req_op2;
    assign dividend     = dividend_s;
    assign divisor      = divisor_s;
    assign unit_o_ready = (state_r == BUSY);
    assign unit_flush   = flush_flag;
    assign stall_req    = accept_s || (state_r == BUSY) || ((state_r == DONE) && !ready_flag);
    assign o_valid      = o_valid_r;
    assign res          = res_r;
    assign busy_cycles  = busy_cycles_r;

    // Next-state and result capture; flush overrides completion and ready
    always_comb begin
        state_nxt_s = state_r;
        res_nxt_s   = res_r;
        if (flush_flag) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && special_s) begin
                        res_nxt_s   = fmt_result(1'b1, 1'b0, req_div_rem, req_word,
                                                 ZERO, ZERO, spec_q_s, spec_r_s);
                        state_nxt_s = DONE;
                    end else if (accept_s) begin
                        state_nxt_s = BUSY;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                BUSY: begin
                    if (unit_done_s) begin
                        res_nxt_s   = fmt_result(is_div_r, high_r, rem_r, word_r,
                                                 mul_result_hi, mul_result_lo,
                                                 quotient, remainder);
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = BUSY;
                    end
                end
                DONE: begin
                    if (ready_flag) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State, result, latched op fields and busy counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            res_r         <= ZERO;
            o_valid_r     <= 1'b0;
            busy_cycles_r <= {CNT_W{1'b0}};
            is_div_r      <= 1'b0;
            high_r        <= 1'b0;
            rem_r         <= 1'b0;
            word_r        <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            res_r     <= res_nxt_s;
            o_valid_r <= (state_nxt_s == DONE);
            if (state_r == BUSY) begin
                busy_cycles_r <= busy_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (launch_s) begin
                is_div_r <= req_is_div;
                high_r   <= req_mul_high;
                rem_r    <= req_div_rem;
                word_r   <= req_word;
            end
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl: behavioural mulu/divu units plus a
// RISC-V M-extension reference model driven by directed and random ops.
module tb_mdu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_flag, ready_flag, req_valid, req_is_div;
    logic [1:0]  req_mul_signed;
    logic        req_mul_high, req_div_signed, req_div_rem, req_word;
    logic [63:0] req_op1, req_op2;
    logic        mul_valid, div_valid, div_signed, mul_o_valid, div_o_valid;
    logic [1:0]  mul_signed;
    logic [63:0] mul_a, mul_b, mul_result_hi, mul_result_lo;
    logic [63:0] dividend, divisor, quotient, remainder, res;
    logic        unit_o_ready, unit_flush, stall_req, o_valid;
    logic [31:0] busy_cycles;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_issue_ctrl #(.XLEN(64), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush_flag(flush_flag), .ready_flag(ready_flag),
        .req_valid(req_valid), .req_is_div(req_is_div), .req_mul_signed(req_mul_signed),
        .req_mul_high(req_mul_high), .req_div_signed(req_div_signed),
        .req_div_rem(req_div_rem), .req_word(req_word), .req_op1(req_op1), .req_op2(req_op2),
        .mul_valid(mul_valid), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
        .mul_o_valid(mul_o_valid), .mul_result_hi(mul_result_hi), .mul_result_lo(mul_result_lo),
        .div_valid(div_valid), .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
        .div_o_valid(div_o_valid), .quotient(quotient), .remainder(remainder),
        .unit_o_ready(unit_o_ready), .unit_flush(unit_flush), .stall_req(stall_req),
        .o_valid(o_valid), .res(res), .busy_cycles(busy_cycles)
    );

    // Behavioural iterative units with programmable latency
    int          mul_lat = 4, div_lat = 4;
    bit          div_ign_flush = 1'b0;
    int          mcnt, dcnt;
    logic signed [129:0] sa, sb;

    function automatic logic [127:0] unit_div(input logic [63:0] a, input logic [63:0] b,
                                              input logic sg);
        logic [63:0] q, r;
        if (b == 64'd0) begin q = '1; r = a; end
        else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 64'd0; end
        else if (sg) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
        else begin q = a / b; r = a % b; end
        return {q, r};
    endfunction

    assign sa = $signed({{66{mul_signed[1] & mul_a[63]}}, mul_a});
    assign sb = $signed({{66{mul_signed[0] & mul_b[63]}}, mul_b});

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcnt <= 0;
        else if (unit_flush) mcnt <= 0;
        else if (mul_valid) begin
            mcnt <= mul_lat;
            {mul_result_hi, mul_result_lo} <= 128'(sa * sb);
        end else if (mcnt > 0) mcnt <= mcnt - 1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dcnt <= 0;
        else if (unit_flush && !div_ign_flush) dcnt <= 0;
        else if (div_valid) begin
            dcnt <= div_lat;
            {quotient, remainder} <= unit_div(dividend, divisor, div_signed);
        end else if (dcnt > 0) dcnt <= dcnt - 1;
    end

    assign mul_o_valid = (mcnt == 1);
    assign div_o_valid = (dcnt == 1);

    typedef struct {
        logic        is_div;
        logic [1:0]  msign;
        logic        high, dsign, rem, word;
        logic [63:0] op1, op2;
    } op_t;

    function automatic op_t mk(input logic is_div, input logic [1:0] ms, input logic hi,
                               input logic ds, input logic rm, input logic wd,
                               input logic [63:0] a, input logic [63:0] b);
        op_t o;
        o.is_div = is_div; o.msign = ms; o.high = hi; o.dsign = ds;
        o.rem = rm; o.word = wd; o.op1 = a; o.op2 = b;
        return o;
    endfunction

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Architectural result of an M-extension op, straight from the ISA rules
    function automatic void ref_model(input op_t o, output logic [63:0] r, output bit sp);
        logic [127:0] a128, b128, p;
        logic [31:0]  a32, b32, q32, m32;
        logic [63:0]  q, m;
        sp = 1'b0;
        a32 = o.op1[31:0]; b32 = o.op2[31:0];
        if (!o.is_div) begin
            a128 = o.msign[1] ? {{64{o.op1[63]}}, o.op1} : {64'd0, o.op1};
            b128 = o.msign[0] ? {{64{o.op2[63]}}, o.op2} : {64'd0, o.op2};
            p = a128 * b128;
            if (o.word) begin
                q32 = a32 * b32;
                r = sx32(q32);
            end else r = o.high ? p[127:64] : p[63:0];
        end else if (o.word) begin
            if (b32 == 32'd0) begin q32 = '1; m32 = a32; sp = 1'b1; end
            else if (o.dsign && a32 == 32'h8000_0000 && b32 == '1) begin
                q32 = a32; m32 = 32'd0; sp = 1'b1;
            end else if (o.dsign) begin
                q32 = $signed(a32) / $signed(b32); m32 = $signed(a32) % $signed(b32);
            end else begin q32 = a32 / b32; m32 = a32 % b32; end
            r = sx32(o.rem ? m32 : q32);
        end else begin
            if (o.op2 == 64'd0) begin q = '1; m = o.op1; sp = 1'b1; end
            else if (o.dsign && o.op1 == 64'h8000_0000_0000_0000 && o.op2 == '1) begin
                q = o.op1; m = 64'd0; sp = 1'b1;
            end else if (o.dsign) begin
                q = $signed(o.op1) / $signed(o.op2); m = $signed(o.op1) % $signed(o.op2);
            end else begin q = o.op1 / o.op2; m = o.op1 % o.op2; end
            r = o.rem ? m : q;
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input op_t o);
        req_is_div = o.is_div; req_mul_signed = o.msign; req_mul_high = o.high;
        req_div_signed = o.dsign; req_div_rem = o.rem; req_word = o.word;
        req_op1 = o.op1; req_op2 = o.op2;
    endtask

    // One full transaction from the accept cycle to o_valid falling
    task automatic do_op(input op_t o, input int lat, input int rdly, input bit chain);
        logic [63:0] exp_res, exp_a, exp_b;
        logic [31:0] b0, bd;
        bit sp;
        int n;
        ref_model(o, exp_res, sp);
        mul_lat = lat; div_lat = lat;
        set_req(o); req_valid = 1'b1; ready_flag = 1'b0;
        #1;
        chk("accept_stall", {63'd0, stall_req}, 64'd1);
        chk("mul_start", {63'd0, mul_valid}, {63'd0, !o.is_div});
        chk("div_start", {63'd0, div_valid}, {63'd0, o.is_div && !sp});
        chk("mul_signed", {62'd0, mul_signed}, {62'd0, o.msign});
        if (o.is_div && !sp) begin
            exp_a = o.word ? (o.dsign ? sx32(o.op1[31:0]) : {32'd0, o.op1[31:0]}) : o.op1;
            exp_b = o.word ? (o.dsign ? sx32(o.op2[31:0]) : {32'd0, o.op2[31:0]}) : o.op2;
            chk("dividend", dividend, exp_a);
            chk("divisor", divisor, exp_b);
        end else if (!o.is_div) begin
            chk("mul_a", mul_a, o.op1);
            chk("mul_b", mul_b, o.op2);
        end
        b0 = busy_cycles;
        n = 0;
        step();
        while (!o_valid && n < 60) begin
            chk("busy_stall", {63'd0, stall_req}, 64'd1);
            chk("busy_ready", {63'd0, unit_o_ready}, 64'd1);
            chk("no_repulse", {62'd0, mul_valid, div_valid}, 64'd0);
            n++;
            step();
        end
        chk("latency", 64'(n + 1), sp ? 64'd1 : 64'(lat + 1));
        chk("res", res, exp_res);
        bd = busy_cycles - b0;
        chk("busy_cycles", {32'd0, bd}, sp ? 64'd0 : 64'(lat));
        for (int k = 0; k < rdly; k++) begin
            chk("done_stall", {63'd0, stall_req}, 64'd1);
            step();
            chk("done_hold_v", {63'd0, o_valid}, 64'd1);
            chk("done_hold_res", res, exp_res);
        end
        ready_flag = 1'b1;
        req_valid = chain;
        #1;
        chk("ready_stall", {63'd0, stall_req}, 64'd0);
        chk("ready_no_start", {62'd0, mul_valid, div_valid}, 64'd0);
        step();
        ready_flag = 1'b0;
        chk("o_valid_fall", {63'd0, o_valid}, 64'd0);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'($urandom_range(0, 20));
            4: return {32'h0, 32'h8000_0000} | ({64{$urandom_range(0, 1) == 1}} & 64'hFFFF_FFFF_0000_0000);
            5: return {32'($urandom), 32'hFFFF_FFFF};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        logic [31:0] b0;
        bit ch;
        rst_n = 1'b0; flush_flag = 1'b0; ready_flag = 1'b0; req_valid = 1'b0;
        set_req(mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_res", res, 64'd0);
        chk("rst_busy", {32'd0, busy_cycles}, 64'd0);
        chk("rst_stall", {63'd0, stall_req}, 64'd0);
        rst_n = 1'b1;
        step();

        // MUL 7 * -3 signed, 4-cycle unit
        do_op(mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD), 4, 0, 1'b0);
        chk("mul_plan", res, 64'hFFFF_FFFF_FFFF_FFEB);
        // DIVU / REMU by zero
        do_op(mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 64'h1234, 64'd0), 3, 0, 1'b0);
        chk("divu0_plan", res, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 64'h1234, 64'd0), 3, 1, 1'b0);
        chk("remu0_plan", res, 64'h1234);
        // DIVW / REMW overflow
        do_op(mk(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF), 3, 0, 1'b0);
        chk("divw_ovf_plan", res, 64'hFFFF_FFFF_8000_0000);
        do_op(mk(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF), 3, 0, 1'b0);
        chk("remw_ovf_plan", res, 64'd0);
        // DIVUW with garbage upper operand bits
        do_op(mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd3), 5, 0, 1'b0);
        chk("divuw_plan", res, 64'd5);

        // Flush on the 2nd BUSY cycle; divider deliberately answers late
        div_lat = 6; div_ign_flush = 1'b1;
        set_req(mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 64'd100, 64'd7));
        req_valid = 1'b1;
        #1;
        chk("fl_div_start", {63'd0, div_valid}, 64'd1);
        b0 = busy_cycles;
        step();
        step();
        flush_flag = 1'b1;
        #1;
        chk("fl_unit_flush", {63'd0, unit_flush}, 64'd1);
        chk("fl_stall", {63'd0, stall_req}, 64'd1);
        step();
        flush_flag = 1'b0; req_valid = 1'b0;
        #1;
        chk("fl_idle_stall", {63'd0, stall_req}, 64'd0);
        for (int k = 0; k < 8; k++) begin
            chk("fl_no_valid", {63'd0, o_valid}, 64'd0);
            step();
        end
        chk("fl_busy", {32'd0, busy_cycles - b0}, 64'd2);
        div_ign_flush = 1'b0;

        // Flush alongside an IDLE request: nothing starts
        set_req(mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 64'd3, 64'd4));
        req_valid = 1'b1; flush_flag = 1'b1;
        #1;
        chk("fi_no_start", {62'd0, mul_valid, div_valid}, 64'd0);
        chk("fi_stall", {63'd0, stall_req}, 64'd0);
        step();
        flush_flag = 1'b0; req_valid = 1'b0;
        #1;
        chk("fi_no_valid", {63'd0, o_valid}, 64'd0);
        step();

        // DONE held 3 cycles, then a request in the ready cycle waits one cycle
        o = mk(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_0000_1111_2222);
        do_op(o, 2, 3, 1'b1);
        do_op(o, 3, 0, 1'b0);

        // Randomised ops against the reference model
        for (int i = 0; i < 40; i++) begin
            o = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   pick(), pick());
            ch = ($urandom_range(0, 3) == 0);
            do_op(o, $urandom_range(1, 6), $urandom_range(0, 2), ch);
            if (ch) do_op(o, $urandom_range(1, 6), 0, 1'b0);
        end

        // Asynchronous reset in the middle of a multiply
        mul_lat = 6;
        set_req(mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 64'd9, 64'd9));
        req_valid = 1'b1;
        step();
        step();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ar_o_valid", {63'd0, o_valid}, 64'd0);
        chk("ar_res", res, 64'd0);
        chk("ar_busy", {32'd0, busy_cycles}, 64'd0);
        chk("ar_stall", {63'd0, stall_req}, 64'd0);
        rst_n = 1'b1;
        step();
        step();
        chk("ar_idle_busy", {32'd0, busy_cycles}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Issue and sequencing controller for the shared iterative multiplier (mulu) and divider (divu) in the EX stage.
- Accepts one M-extension op at a time from ID/EX and prepares the operands (word extension).
- Launches the correct unit, holds the EX stall, and captures and formats the result.
- Resolves RISC-V divide-by-zero and signed-overflow cases itself without launching divu; propagates pipeline flush to the units.

Parameters:
XLEN, 64, datapath width (the block is built for 64; 32 must also elaborate).
CNT_W, 32, width of the busy-cycle performance counter.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush_flag  input  1  pipeline flush; kills any in-flight op.
ready_flag  input  1  downstream stage accepts result this cycle.
req_valid  input  1  ID/EX holds a valid mul/div op (already qualified by trap/data-conflict).
req_is_div  input  1  1 = div/rem, 0 = mul.
req_mul_signed  input  2  {op1_signed, op2_signed} for mul.
req_mul_high  input  1  return high XLEN bits.
req_div_signed  input  1  signed divide.
req_div_rem  input  1  return remainder.
req_word  input  1  *W variant.
req_op1  input  XLEN  operand 1.
req_op2  input  XLEN  operand 2.
mul_valid  output  1  start pulse to mulu.
mul_signed  output  2  pass-through of req_mul_signed.
mul_a, mul_b  output  XLEN each  multiplier operands.
mul_o_valid  input  1  mulu result valid.
mul_result_hi, mul_result_lo  input  XLEN each  mulu result.
div_valid  output  1  start pulse to divu.
div_signed  output  1  pass-through of req_div_signed.
dividend, divisor  output  XLEN each  extended divider operands.
div_o_valid  input  1  divu result valid.
quotient, remainder  input  XLEN each  divu result.
unit_o_ready  output  1  result handshake ready to mulu/divu.
unit_flush  output  1  flush to mulu/divu.
stall_req  output  1  holds the EX stage.
o_valid  output  1  res valid.
res  output  XLEN  formatted result.
busy_cycles  output  CNT_W  count of cycles spent in BUSY.

Behaviour:
- Reset: state = IDLE; o_valid = 0; res = 0; busy_cycles = 0; latched op fields = 0.
- States: IDLE, BUSY, DONE.
- Operand prep (combinational):
  - Word div: op1[31:0] and op2[31:0] are sign-extended if req_div_signed, else zero-extended.
  - Word mul: raw operands pass through.
  - Non-word: raw operands.
- Accept: accept = (state == IDLE) & req_valid & !flush_flag.
- Special division cases (checked on the prepared operands):
  - div0 = (divisor == 0).
  - ovf = req_div_signed & (dividend == most-negative) & (divisor == all-ones); for word ops, tested on bits [31:0] after extension.
- IDLE, on accept:
  - Div with div0 or ovf: no unit start. res loads the special value and the state goes to DONE. Latency: 1 cycle from accept to o_valid.
    - div0: quotient = all-ones; remainder = dividend.
    - ovf: quotient = dividend; remainder = 0.
  - Otherwise: mul_valid or div_valid is high for exactly the accept cycle (combinational). Op fields (is_div, high, rem, word) are latched. State goes to BUSY.
- BUSY:
  - unit_o_ready = 1.
  - On the o_valid of the latched unit, capture the formatted result into res and go to DONE.
  - Result formatting:
    - word: sign-extend selected[31:0]; mul word uses lo.
    - mul non-word: hi if high, else lo.
    - div non-word: remainder if rem, else quotient.
  - The other unit's o_valid is ignored.
- DONE:
  - o_valid = 1 and res is held stable.
  - If ready_flag, go to IDLE; o_valid falls on the next cycle.
  - A new request is not accepted in the same cycle (minimum issue interval 2 cycles after DONE).
- stall_req = accept | (state == BUSY) | ((state == DONE) & !ready_flag).
- Flush:
  - unit_flush = flush_flag (combinational).
  - Any state goes to IDLE next cycle and o_valid = 0; flush has priority over unit completion and ready_flag.
  - Flush during an IDLE request: no start pulse.
  - res keeps its last value after flush; it is don't-care while o_valid = 0.
- req_valid and the req_* fields seen outside IDLE are ignored; upstream holds them stable while stalled.
- busy_cycles increments by 1 every cycle state == BUSY and wraps modulo 2^CNT_W.
- An asynchronous reset mid-operation returns all state to its reset values immediately; the units are reset by the same rst_n.

Test Plan:
- MUL, op1 = 7, op2 = -3 (0xFFFF_FFFF_FFFF_FFFD), mul_signed = 2'b11, mulu model with 4-cycle latency -> mul_valid is a single pulse; stall_req stays high; o_valid 5 cycles after accept with res = 0xFFFF_FFFF_FFFF_FFEB; busy_cycles = 4.
- DIVU with op2 = 0, op1 = 0x1234 -> no div_valid; o_valid on the next cycle with res = 0xFFFF_FFFF_FFFF_FFFF. Same case with REMU -> res = 0x1234.
- DIVW, op1 = 0x0000_0000_8000_0000, op2 = 0xFFFF_FFFF, signed -> ovf path; res = 0xFFFF_FFFF_8000_0000. REMW with the same operands -> res = 0.
- DIVUW, op1 = 0xFFFF_FFFF_0000_0010, op2 = 3 -> dividend = 0x10; res = 5 (sign-extended).
- Flush asserted on the 2nd BUSY cycle -> unit_flush high that cycle; IDLE next cycle; o_valid never rises. A late div_o_valid after the flush is ignored.
- DONE with ready_flag held low for 3 cycles -> o_valid, res and stall_req held; ready_flag = 1 -> o_valid = 0 next cycle. A req_valid presented in that ready cycle is not accepted until the following cycle.
